sequence_hit_logger: RTL and testbench

Downstream consumer of the four-in-a-row sequence detector's `z` output (LEDG[0]). Samples `z` once per detector step, counts distinct detection events and total hit steps, tracks current and longest hit-burst length, and raises a sticky alarm after a programmable number of events. Drives two active-low 7-segment digits showing the event count for the board display.

---
 rtl/sequence_hit_logger_pkg.sv | 34 +++
 rtl/sequence_hit_logger_hex7seg_decoder.sv | 14 +
 rtl/sequence_hit_logger.sv | 124 ++++++++++++
 tb/tb_sequence_hit_logger.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sequence_hit_logger_pkg.sv
// Shared definitions for the sequence hit logger and board display blocks.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sequence_hit_logger_pkg;

    // Hit-burst FSM encoding, kept as plain constants for legacy compatibility.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // Active-low 7-segment patterns, bit order g..a, indexed by hex digit.
    // Entry 15 sits at the left so that SEG7_LUT[n] returns the pattern for n.
    localparam logic [15:0][6:0] SEG7_LUT = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    // Segment pattern shown when a digit position has nothing to display.
    localparam logic [6:0] SEG7_BLANK = 7'h7F;

endpackage

// File: rtl/sequence_hit_logger_hex7seg_decoder.sv
// Hex digit to active-low 7-segment decode (segments g..a).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input continuously.
module hex7seg_decoder
    import sequence_hit_logger_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    // Table lookup shared with the other display blocks.
    assign seg = SEG7_LUT[value];

endmodule

// File: rtl/sequence_hit_logger.sv
// Counts detection events, hit steps and burst lengths from the detector's z output; sticky alarm.
// Latency: a step sampled on a rising edge is visible on every output right after that edge.
// Backpressure: none; every En cycle is consumed, back-to-back steps are allowed.
module sequence_hit_logger
    import sequence_hit_logger_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int ALARM_EVENTS = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             Z,
    input  logic             Clr,
    output logic [CNT_W-1:0] EventCount,
    output logic [CNT_W-1:0] HitSteps,
    output logic [CNT_W-1:0] BurstLen,
    output logic [CNT_W-1:0] MaxBurst,
    output logic             InBurst,
    output logic             Alarm,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1
);

    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] ALARM_AT   = CNT_W'(ALARM_EVENTS);

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [CNT_W-1:0] event_nxt;
    logic [CNT_W-1:0] hit_nxt;
    logic [CNT_W-1:0] burst_nxt;
    logic [CNT_W-1:0] max_nxt;
    logic             alarm_nxt;

    // Saturating increments: counters stick at all-ones and never wrap.
    logic [CNT_W-1:0] event_inc;
    logic [CNT_W-1:0] hit_inc;
    logic [CNT_W-1:0] burst_inc;

    assign event_inc = (EventCount == CNT_MAX) ? EventCount : EventCount + CNT_ONE;
    assign hit_inc   = (HitSteps   == CNT_MAX) ? HitSteps   : HitSteps   + CNT_ONE;
    assign burst_inc = (BurstLen   == CNT_MAX) ? BurstLen   : BurstLen   + CNT_ONE;

    // Next-state for one detector step; a non-step cycle holds everything.
    always_comb begin
        state_nxt = state;
        event_nxt = EventCount;
        hit_nxt   = HitSteps;
        burst_nxt = BurstLen;
        max_nxt   = MaxBurst;
        alarm_nxt = Alarm;

        if (En) begin
            if (Z) begin
                hit_nxt   = hit_inc;
                state_nxt = ST_BURST;
                if (state == ST_IDLE) begin
                    // Rising edge of z opens a new event.
                    event_nxt = event_inc;
                    burst_nxt = CNT_ONE;
                    if (MaxBurst == '0) begin
                        max_nxt = CNT_ONE;
                    end
                    // Alarm latches on the step whose event count hits the threshold;
                    // once set it is only released by Clr or reset.
                    if (event_inc == ALARM_AT) begin
                        alarm_nxt = 1'b1;
                    end
                end else begin
                    // Longest burst tracks the running burst, not just closed ones.
                    burst_nxt = burst_inc;
                    if (burst_inc > MaxBurst) begin
                        max_nxt = burst_inc;
                    end
                end
            end else begin
                state_nxt = ST_IDLE;
                burst_nxt = '0;
            end
        end
    end

    // Register update: reset beats clear, clear beats (and discards) a coincident step.
    always_ff @(posedge Clk) begin
        if (!Rst || Clr) begin
            state      <= ST_IDLE;
            EventCount <= '0;
            HitSteps   <= '0;
            BurstLen   <= '0;
            MaxBurst   <= '0;
            Alarm      <= 1'b0;
        end else begin
            state      <= state_nxt;
            EventCount <= event_nxt;
            HitSteps   <= hit_nxt;
            BurstLen   <= burst_nxt;
            MaxBurst   <= max_nxt;
            Alarm      <= alarm_nxt;
        end
    end

    assign InBurst = (state == ST_BURST);

    // Low digit always shows EventCount[3:0].
    hex7seg_decoder u_hex0 (
        .value (EventCount[3:0]),
        .seg   (HEX0)
    );

    // High digit shows EventCount[7:4] when the counter is wide enough, otherwise blank.
    generate
        if (CNT_W >= 8) begin : g_hex1
            hex7seg_decoder u_hex1 (
                .value (EventCount[7:4]),
                .seg   (HEX1)
            );
        end else begin : g_hex1_blank
            assign HEX1 = SEG7_BLANK;
        end
    endgenerate

endmodule

// File: tb/tb_sequence_hit_logger.sv
// Scoreboard bench: an unsaturated event/run model predicts each edge, a monitor compares two widths.
// Latency: expectation for a cycle is pushed at the negedge before the edge that it describes.
// Backpressure: none; the monitor drains one expectation per rising edge.
module tb_sequence_hit_logger;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic Rst = 1'b0;
    logic En  = 1'b0;
    logic Z   = 1'b0;
    logic Clr = 1'b0;

    logic [7:0] a_ev, a_hs, a_bl, a_mb;
    logic       a_inb, a_alarm;
    logic [6:0] a_hex0, a_hex1;
    logic [3:0] b_ev, b_hs, b_bl, b_mb;
    logic       b_inb, b_alarm;
    logic [6:0] b_hex0, b_hex1;

    sequence_hit_logger #(.CNT_W(8), .ALARM_EVENTS(4)) dut8 (
        .Clk(Clk), .Rst(Rst), .En(En), .Z(Z), .Clr(Clr),
        .EventCount(a_ev), .HitSteps(a_hs), .BurstLen(a_bl), .MaxBurst(a_mb),
        .InBurst(a_inb), .Alarm(a_alarm), .HEX0(a_hex0), .HEX1(a_hex1)
    );

    sequence_hit_logger #(.CNT_W(4), .ALARM_EVENTS(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .En(En), .Z(Z), .Clr(Clr),
        .EventCount(b_ev), .HitSteps(b_hs), .BurstLen(b_bl), .MaxBurst(b_mb),
        .InBurst(b_inb), .Alarm(b_alarm), .HEX0(b_hex0), .HEX1(b_hex1)
    );

    // Expected true (unbounded) statistics after an edge; saturation applied at compare time.
    typedef struct {
        int ev;
        int hs;
        int run;
        int maxrun;
    } exp_t;

    exp_t exp_q[$];

    int m_ev = 0, m_hs = 0, m_run = 0, m_max = 0;
    int n_cmp = 0, n_bad = 0;

    // Independent reference of the digit glyphs, g..a active-low.
    logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic int sat(int v, int w);
        int lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic chk(string name, int act, int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // Drive one cycle and record what the model says the following edge must produce.
    task automatic step(bit rst_n, bit clr, bit en, bit z);
        exp_t e;
        @(negedge Clk);
        Rst = rst_n;
        Clr = clr;
        En  = en;
        Z   = z;
        if (!rst_n || clr) begin
            m_ev = 0; m_hs = 0; m_run = 0; m_max = 0;
        end else if (en) begin
            if (z) begin
                if (m_run == 0) m_ev++;
                m_hs++;
                m_run++;
                if (m_run > m_max) m_max = m_run;
            end else begin
                m_run = 0;
            end
        end
        e.ev = m_ev; e.hs = m_hs; e.run = m_run; e.maxrun = m_max;
        exp_q.push_back(e);
    endtask

    // Monitor: one output set per rising edge, checked 1 time unit after the edge.
    always @(posedge Clk) begin
        exp_t e;
        int ev8, ev4;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ev8 = sat(e.ev, 8);
            ev4 = sat(e.ev, 4);
            chk("ev8",    int'(a_ev),    ev8);
            chk("hits8",  int'(a_hs),    sat(e.hs, 8));
            chk("blen8",  int'(a_bl),    sat(e.run, 8));
            chk("maxb8",  int'(a_mb),    sat(e.maxrun, 8));
            chk("inb8",   int'(a_inb),   int'(e.run > 0));
            chk("alarm8", int'(a_alarm), int'(e.ev >= 4));
            chk("hex0_8", int'(a_hex0),  int'(segtab[ev8 & 15]));
            chk("hex1_8", int'(a_hex1),  int'(segtab[(ev8 >> 4) & 15]));
            chk("ev4",    int'(b_ev),    ev4);
            chk("hits4",  int'(b_hs),    sat(e.hs, 4));
            chk("blen4",  int'(b_bl),    sat(e.run, 4));
            chk("maxb4",  int'(b_mb),    sat(e.maxrun, 4));
            chk("inb4",   int'(b_inb),   int'(e.run > 0));
            chk("alarm4", int'(b_alarm), int'(e.ev >= 4));
            chk("hex0_4", int'(b_hex0),  int'(segtab[ev4]));
            chk("hex1_4", int'(b_hex1),  32'h7F);
        end
    end

    initial begin
        // Reset for two cycles.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Burst counting: z = 1,1,1,0,1,0.
        step(1, 0, 1, 1); step(1, 0, 1, 1); step(1, 0, 1, 1);
        step(1, 0, 1, 0); step(1, 0, 1, 1); step(1, 0, 1, 0);
        step(1, 1, 0, 0);

        // En gating: z held high with no step, then an idle step.
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1);
        step(1, 0, 1, 0);

        // Alarm: seven isolated events, then clear.
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 1, 1);
            step(1, 0, 1, 0);
        end
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);

        // Saturation: twenty consecutive hit steps (4-bit instance pins at 15).
        for (int i = 0; i < 20; i++) step(1, 0, 1, 1);

        // Clear colliding with a hit step discards the step.
        step(1, 1, 1, 1);
        step(1, 0, 1, 0);

        // Reset mid-burst, then a fresh hit starts a new event.
        step(1, 0, 1, 1); step(1, 0, 1, 1);
        step(0, 0, 1, 1);
        step(1, 0, 1, 1);
        step(1, 0, 1, 0);

        // Random traffic with occasional clear/reset.
        for (int i = 0; i < 3000; i++) begin
            bit r, c, e, z;
            r = ($urandom_range(0, 199) != 0);
            c = ($urandom_range(0, 149) == 0);
            e = ($urandom_range(0, 9) < 7);
            z = ($urandom_range(0, 9) < 6);
            step(r, c, e, z);
        end

        // Long hit run so the 8-bit counters also saturate.
        step(1, 1, 0, 0);
        for (int i = 0; i < 300; i++) step(1, 0, 1, 1);
        step(1, 0, 1, 0);

        // Drain the scoreboard within a bounded number of edges.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
